// File: rtl/branch_redirect_unit.sv
// PC owner and redirect/flush control for the EX-resolved branch path.
// A taken branch or jump reloads the PC and squashes IF/ID and ID/EX.
// The unit then ignores EX redirect requests for SHADOW cycles, and it also keeps branch statistics.
module branch_redirect_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          SHADOW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic              ex_jump,
    input  logic [ADDR_W-1:0] ex_target,
    output logic [ADDR_W-1:0] pc,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              in_shadow,
    output logic              bad_target,
    output logic [15:0]       branch_cnt,
    output logic [15:0]       taken_cnt
);

    typedef enum logic {
        RUN       = 1'b0,
        SHADOW_ST = 1'b1
    } state_t;

    // The shadow counter is loaded with SHADOW-1 so that the unit stays in the shadow state for exactly SHADOW cycles.
    localparam logic [2:0] SHADOW_INIT = (SHADOW > 0) ? 3'(SHADOW - 1) : 3'd0;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_t            state;
    logic [2:0]        cnt;
    logic              req;
    logic              take;
    logic              branch_seen;
    logic [ADDR_W-1:0] aligned_target;

    assign req            = ex_valid & ((ex_branch & ex_zero) | ex_jump);
    assign take           = req & (state == RUN);
    assign branch_seen    = ex_valid & ex_branch & (state == RUN);
    assign aligned_target = {ex_target[ADDR_W-1:2], 2'b00};

    assign flush_ifid = take;
    assign flush_idex = take;
    assign in_shadow  = (state == SHADOW_ST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    if (take && (SHADOW > 0)) begin
                        state <= SHADOW_ST;
                        cnt   <= SHADOW_INIT;
                    end
                end
                SHADOW_ST: begin
                    // Stall does not freeze the window; it counts real cycles.
                    if (cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    // A redirect beats a load-use stall, because the stalled instruction is being squashed anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (take) begin
            pc <= aligned_target;
        end else if (!stall) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= 16'd0;
            taken_cnt  <= 16'd0;
            bad_target <= 1'b0;
        end else begin
            if (branch_seen) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (take) begin
                taken_cnt <= taken_cnt + 16'd1;
                if (ex_target[1:0] != 2'b00) begin
                    bad_target <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit: one default instance (SHADOW=2)
// and one narrow instance (ADDR_W=8, SHADOW=0) for wrap behaviour.
module tb_branch_redirect_unit;

    logic        clk;
    logic        rst, stall, ex_valid, ex_branch, ex_zero, ex_jump;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        flush_ifid, flush_idex, in_shadow, bad_target;
    logic [15:0] branch_cnt, taken_cnt;

    logic        rst8, stall8, valid8, branch8, zero8, jump8;
    logic [7:0]  target8;
    logic [7:0]  pc8;
    logic        fifid8, fidex8, shadow8, bad8;
    logic [15:0] bcnt8, tcnt8;

    int checks = 0;
    int errors = 0;

    branch_redirect_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_jump(ex_jump),
        .ex_target(ex_target), .pc(pc), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .in_shadow(in_shadow), .bad_target(bad_target),
        .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    branch_redirect_unit #(.ADDR_W(8), .RESET_PC(8'h00), .SHADOW(0)) dut8 (
        .clk(clk), .rst(rst8), .stall(stall8), .ex_valid(valid8),
        .ex_branch(branch8), .ex_zero(zero8), .ex_jump(jump8),
        .ex_target(target8), .pc(pc8), .flush_ifid(fifid8),
        .flush_idex(fidex8), .in_shadow(shadow8), .bad_target(bad8),
        .branch_cnt(bcnt8), .taken_cnt(tcnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; ex_valid = 0; ex_branch = 0; ex_zero = 0; ex_jump = 0;
        ex_target = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #3;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++;
        if ({flush_ifid, flush_idex, in_shadow, bad_target} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {flush_ifid, flush_idex, in_shadow, bad_target});
        end
        checks++;
        if ({branch_cnt, taken_cnt} !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_counters: got %h expected 0", {branch_cnt, taken_cnt});
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL release_pc: got %h expected 0", pc); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", i, pc, 32'(4 * i)); end
        end
        checks++;
        if ({flush_ifid, in_shadow, branch_cnt, taken_cnt} !== 34'h0) begin
            errors++; $display("[TB] FAIL seq_quiet: got %h expected 0", {flush_ifid, in_shadow, branch_cnt, taken_cnt});
        end
    endtask

    task automatic test_taken_branch();
        do_reset();
        repeat (4) tick();
        checks++;
        if (pc !== 32'h10) begin errors++; $display("[TB] FAIL tb_start_pc: got %h expected 10", pc); end
        ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_target = 32'h40;
        #1;
        checks++;
        if ({flush_ifid, flush_idex} !== 2'b11) begin errors++; $display("[TB] FAIL tb_flush: got %b expected 11", {flush_ifid, flush_idex}); end
        tick();
        ex_target = 32'h80;
        #1;
        checks++;
        if (pc !== 32'h40) begin errors++; $display("[TB] FAIL tb_pc_target: got %h expected 40", pc); end
        checks++;
        if ({in_shadow, flush_ifid, flush_idex} !== 3'b100) begin
            errors++; $display("[TB] FAIL tb_shadow1: got %b expected 100", {in_shadow, flush_ifid, flush_idex});
        end
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd1, 16'd1}) begin
            errors++; $display("[TB] FAIL tb_counts: got %h expected 00010001", {branch_cnt, taken_cnt});
        end
        tick();
        checks++;
        if ({pc, in_shadow, flush_ifid} !== {32'h44, 2'b10}) begin
            errors++; $display("[TB] FAIL tb_shadow2: got %h expected %h", {pc, in_shadow, flush_ifid}, {32'h44, 2'b10});
        end
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd1, 16'd1}) begin
            errors++; $display("[TB] FAIL tb_ignored_req: got %h expected 00010001", {branch_cnt, taken_cnt});
        end
        clear_inputs();
        tick();
        checks++;
        if ({pc, in_shadow} !== {32'h48, 1'b0}) begin
            errors++; $display("[TB] FAIL tb_after_shadow: got %h expected %h", {pc, in_shadow}, {32'h48, 1'b0});
        end
    endtask

    task automatic test_not_taken_stall();
        do_reset();
        ex_valid = 1; ex_branch = 1; ex_zero = 0; stall = 1;
        #1;
        checks++;
        if ({flush_ifid, flush_idex} !== 2'b00) begin errors++; $display("[TB] FAIL nt_flush: got %b expected 00", {flush_ifid, flush_idex}); end
        tick();
        clear_inputs();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (pc !== 32'h0) begin errors++; $display("[TB] FAIL nt_hold%0d: got %h expected 0", i, pc); end
            tick();
        end
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL nt_hold2: got %h expected 0", pc); end
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd1, 16'd0}) begin
            errors++; $display("[TB] FAIL nt_counts: got %h expected 00010000", {branch_cnt, taken_cnt});
        end
        stall = 0;
        tick();
        checks++;
        if (pc !== 32'h4) begin errors++; $display("[TB] FAIL nt_resume: got %h expected 4", pc); end
    endtask

    task automatic test_jump_misaligned();
        do_reset();
        tick();
        ex_valid = 1; ex_jump = 1; stall = 1; ex_target = 32'h103;
        tick();
        clear_inputs();
        checks++;
        if (pc !== 32'h100) begin errors++; $display("[TB] FAIL jmp_pc: got %h expected 100", pc); end
        checks++;
        if ({bad_target, branch_cnt, taken_cnt} !== {1'b1, 16'd0, 16'd1}) begin
            errors++; $display("[TB] FAIL jmp_flags: got %h expected %h", {bad_target, branch_cnt, taken_cnt}, {1'b1, 16'd0, 16'd1});
        end
        repeat (3) tick();
        ex_valid = 1; ex_jump = 1; ex_branch = 1; ex_zero = 0; ex_target = 32'h200;
        tick();
        clear_inputs();
        checks++;
        if ({pc, bad_target} !== {32'h200, 1'b1}) begin
            errors++; $display("[TB] FAIL jmp_sticky: got %h expected %h", {pc, bad_target}, {32'h200, 1'b1});
        end
        checks++;
        if ({branch_cnt, taken_cnt} !== {16'd1, 16'd2}) begin
            errors++; $display("[TB] FAIL jmp_branch_too: got %h expected 00010002", {branch_cnt, taken_cnt});
        end
        do_reset();
        checks++;
        if (bad_target !== 1'b0) begin errors++; $display("[TB] FAIL jmp_clear: got %b expected 0", bad_target); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_target = 32'h20;
        tick();
        tick();
        tick();
        checks++;
        if ({pc, in_shadow, flush_ifid} !== {32'h28, 2'b01}) begin
            errors++; $display("[TB] FAIL b2b_reopen: got %h expected %h", {pc, in_shadow, flush_ifid}, {32'h28, 2'b01});
        end
        tick();
        clear_inputs();
        checks++;
        if ({pc, branch_cnt, taken_cnt} !== {32'h20, 16'd2, 16'd2}) begin
            errors++; $display("[TB] FAIL b2b_second: got %h expected %h", {pc, branch_cnt, taken_cnt}, {32'h20, 16'd2, 16'd2});
        end
    endtask

    task automatic test_reset_mid_shadow();
        do_reset();
        ex_valid = 1; ex_jump = 1; ex_target = 32'h40;
        tick();
        clear_inputs();
        #1;
        rst = 1;
        #1;
        checks++;
        if ({pc, in_shadow, flush_ifid, branch_cnt, taken_cnt} !== 66'h0) begin
            errors++; $display("[TB] FAIL rms_async: got %h expected 0", {pc, in_shadow, flush_ifid, branch_cnt, taken_cnt});
        end
        rst = 0;
        ex_valid = 1; ex_jump = 1; ex_target = 32'h60;
        #1;
        checks++;
        if (flush_idex !== 1'b1) begin errors++; $display("[TB] FAIL rms_flush: got %b expected 1", flush_idex); end
        tick();
        clear_inputs();
        checks++;
        if ({pc, taken_cnt, in_shadow} !== {32'h60, 16'd1, 1'b1}) begin
            errors++; $display("[TB] FAIL rms_honoured: got %h expected %h", {pc, taken_cnt, in_shadow}, {32'h60, 16'd1, 1'b1});
        end
    endtask

    task automatic test_wrap();
        rst8 = 1; stall8 = 0; valid8 = 0; branch8 = 0; zero8 = 0; jump8 = 0; target8 = 8'h00;
        tick();
        rst8 = 0;
        valid8 = 1; branch8 = 1; zero8 = 1; target8 = 8'hFC;
        tick();
        valid8 = 0;
        checks++;
        if ({pc8, shadow8} !== {8'hFC, 1'b0}) begin errors++; $display("[TB] FAIL wrap_load: got %h expected %h", {pc8, shadow8}, {8'hFC, 1'b0}); end
        tick();
        checks++;
        if (pc8 !== 8'h00) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 00", pc8); end
        valid8 = 1;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if ({bcnt8, tcnt8} !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_max: got %h expected ffffffff", {bcnt8, tcnt8}); end
        tick();
        valid8 = 0;
        checks++;
        if ({bcnt8, tcnt8} !== 32'h0) begin errors++; $display("[TB] FAIL wrap_cnt: got %h expected 0", {bcnt8, tcnt8}); end
    endtask

    initial begin
        rst8 = 1; stall8 = 0; valid8 = 0; branch8 = 0; zero8 = 0; jump8 = 0; target8 = 8'h00;
        test_reset();
        test_taken_branch();
        test_not_taken_stall();
        test_jump_misaligned();
        test_back_to_back();
        test_reset_mid_shadow();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Owns the program counter of the pipelined CPU and consumes the EX-stage branch decision (`branch & zero`) and jump requests. On a taken control transfer it redirects the PC, flushes the younger pipeline registers, and masks further redirects for a configurable shadow window. It also keeps branch statistics. It sits between the EX stage and the IF stage as the PC-select/flush side of the branch path.

## Interface
- `ADDR_W`, 32, PC/target width (≥ 8).
- `RESET_PC`, 0, PC value after reset.
- `SHADOW`, 2, cycles after a redirect during which EX redirect requests are masked (0..7).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  load-use stall; holds the PC.
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_branch`  in  1  EX instruction is a conditional branch.
- `ex_zero`  in  1  ALU zero flag.
- `ex_jump`  in  1  EX instruction is an unconditional jump.
- `ex_target`  in  ADDR_W  branch/jump target computed in EX.
- `pc`  out  ADDR_W  current fetch address (registered).
- `flush_ifid`  out  1  squash IF/ID this cycle.
- `flush_idex`  out  1  squash ID/EX this cycle.
- `in_shadow`  out  1  unit is in the SHADOW state.
- `bad_target`  out  1  sticky flag: a redirect target was not word-aligned.
- `branch_cnt`  out  16  conditional branches resolved (wrapping).
- `taken_cnt`  out  16  redirects performed (wrapping).

## Operation
- `req` = `ex_valid & ((ex_branch & ex_zero) | ex_jump)`.
- `take` = `req & (state == RUN)`.
- States:
  - RUN: `take` loads `pc <= {ex_target[ADDR_W-1:2], 2'b00}` at the next edge.
    - If `SHADOW > 0`, also go to SHADOW with `cnt <= SHADOW-1`.
    - If `SHADOW == 0`, stay in RUN.
  - SHADOW: `req` is ignored; `cnt` decrements each cycle; return to RUN on the edge where `cnt == 0`.
- PC update priority, per edge:
  1. `take`
  2. `stall` (PC holds)
  3. otherwise `pc <= pc + 4`, wrapping modulo 2^ADDR_W.
- `take` overrides `stall`.
- `stall` does not pause the SHADOW counter.
- `flush_ifid = flush_idex = take` (combinational, same cycle as `take`).
- `in_shadow = (state == SHADOW)`.
- Statistics and flags:
  - `branch_cnt` increments when `ex_valid & ex_branch & (state == RUN)`, taken or not.
  - `taken_cnt` increments on `take`.
  - Both counters wrap 0xFFFF → 0.
  - `bad_target` is set on `take` with `ex_target[1:0] != 0`; it is cleared only by reset.
  - A jump that is also flagged as a branch counts as one branch and one redirect.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-SHADOW):
  - `pc = RESET_PC`, state RUN, `cnt = 0`.
  - `bad_target = 0`, `branch_cnt = taken_cnt = 0`.
  - `flush_*` follow `take`, so they are 0 while `ex_valid = 0`.
- Redirect latency:
  - `take` in cycle T drives `flush_*` high in T.
  - `pc` equals the target from T+1.
  - `in_shadow` is high for T+1 .. T+SHADOW.
  - The earliest next honoured `req` is in cycle T+SHADOW+1.
- `req` during SHADOW: no PC change, no flush, no counter change.
- `stall` with no `take`: `pc` is stable for every stalled cycle.
- Deassertion of `rst` needs no settling cycle; the first edge after release advances `pc` to `RESET_PC+4`, unless `stall` or `take` applies.

## Test plan
- Reset/sequential fetch: release `rst` with all inputs 0 → `pc` = 0, 4, 8, 12 on successive edges; all outputs otherwise 0.
- Taken branch, `SHADOW=2`: at `pc=0x10`, `ex_valid=ex_branch=ex_zero=1`, `ex_target=0x40` →
  - `flush_*` high that cycle only.
  - `pc=0x40`, then 0x44, 0x48.
  - `in_shadow` high for 2 cycles.
  - A second `req` during the shadow is ignored.
  - `taken_cnt=1`, `branch_cnt=1`.
- Not-taken plus stall: `ex_branch=1`, `ex_zero=0` with `stall=1` for 3 cycles →
  - `pc` is held for 3 cycles.
  - `branch_cnt=1`, `taken_cnt=0`, no flush.
- Jump overrides stall and is misaligned: `ex_jump=1`, `stall=1`, `ex_target=0x103` →
  - `pc=0x100`.
  - `bad_target=1` and stays 1 until reset.
- Wrap: `ADDR_W=8`, `pc=0xFC` → next `pc=0x00`.
  - Force 65536 redirects → `taken_cnt` returns to 0.
- Reset mid-shadow: assert `rst` one cycle after a redirect →
  - Immediately: `pc=RESET_PC`, `in_shadow=0`, counters 0.
  - The next `req` after release is honoured.
